// File: rtl/aes_256_arbiter.sv
// aes_256_arbiter: round-robin sharing of one pipelined aes_256 core with credit-limited per-requester result FIFOs
module aes_256_arbiter #(
  parameter int NREQ       = 2,
  parameter int LATENCY    = 29,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*128-1:0] req_state,
  input  logic [NREQ*256-1:0] req_key,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [NREQ*128-1:0] rsp_data,
  output logic [127:0]        core_state,
  output logic [255:0]        core_key,
  input  logic [127:0]        core_out
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  logic [IW-1:0] ptr_q, ptr_d, gidx;
  logic found;
  logic [NREQ-1:0] elig, push, pop;
  logic [CW-1:0] cnt_q [NREQ], cnt_d [NREQ], occ_q [NREQ], occ_d [NREQ];
  logic [AW-1:0] wr_q [NREQ], wr_d [NREQ], rd_q [NREQ], rd_d [NREQ];
  logic [127:0] mem_q [NREQ][FIFO_DEPTH], mem_d [NREQ][FIFO_DEPTH];
  logic [LATENCY:0] pv_q, pv_d;
  logic [IW-1:0] pidx_q [LATENCY+1], pidx_d [LATENCY+1];
  logic [127:0] core_state_q, core_state_d;
  logic [255:0] core_key_q, core_key_d;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  assign core_state = core_state_q;
  assign core_key   = core_key_q;
  for (genvar g = 0; g < NREQ; g++) begin : g_rsp
    assign rsp_valid[g] = occ_q[g] != '0;
    assign rsp_data[128*g +: 128] = mem_q[g][rd_q[g]];
  end
  // cnt covers in-flight plus buffered results, so a FIFO can never be overrun
  always_comb begin
    found = 1'b0;
    gidx = ptr_q;
    for (int i = 0; i < NREQ; i++) elig[i] = req_valid[i] && cnt_q[i] < CW'(FIFO_DEPTH);
    for (int k = 1; k <= NREQ; k++)
      if (!found && elig[IW'((int'(ptr_q) + k) % NREQ)]) begin
        found = 1'b1;
        gidx = IW'((int'(ptr_q) + k) % NREQ);
      end
    req_ready = '0;
    if (found && !sys_rst) req_ready[gidx] = 1'b1;
  end
  always_comb begin
    ptr_d = found ? gidx : ptr_q;
    core_state_d = found ? req_state[128*int'(gidx) +: 128] : '0;
    core_key_d = found ? req_key[256*int'(gidx) +: 256] : '0;
    pv_d = {pv_q[LATENCY-1:0], found};
    pidx_d[0] = gidx;
    for (int s = 1; s <= LATENCY; s++) pidx_d[s] = pidx_q[s-1];
    mem_d = mem_q;
    for (int i = 0; i < NREQ; i++) begin
      push[i] = pv_q[LATENCY] && pidx_q[LATENCY] == IW'(i);
      pop[i] = rsp_valid[i] && rsp_ready[i];
      cnt_d[i] = cnt_q[i] + CW'(req_ready[i]) - CW'(pop[i]);
      occ_d[i] = occ_q[i] + CW'(push[i]) - CW'(pop[i]);
      wr_d[i] = push[i] ? nxt(wr_q[i]) : wr_q[i];
      rd_d[i] = pop[i] ? nxt(rd_q[i]) : rd_q[i];
      if (push[i]) mem_d[i][wr_q[i]] = core_out;
    end
  end
  always_ff @(posedge sys_clk) begin
    mem_q <= mem_d;
    pidx_q <= pidx_d;
    if (sys_rst) begin
      ptr_q <= IW'(NREQ - 1);
      pv_q <= '0;
      core_state_q <= '0;
      core_key_q <= '0;
      cnt_q <= '{default: '0};
      occ_q <= '{default: '0};
      wr_q <= '{default: '0};
      rd_q <= '{default: '0};
    end else begin
      ptr_q <= ptr_d;
      pv_q <= pv_d;
      core_state_q <= core_state_d;
      core_key_q <= core_key_d;
      cnt_q <= cnt_d;
      occ_q <= occ_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: tb/tb_aes_256_arbiter.sv
// tb_aes_256_arbiter: directed stimulus with a queue-based reference model and a stub aes_256 core pipeline
module tb_aes_256_arbiter;
  localparam int NREQ = 2, LAT = 29, DEPTH = 4;
  localparam logic [127:0] VA_S = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] VA_K = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] VA_C = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] VB_S = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [255:0] VB_K = 256'h2b7e151628aed2a6abf7158809cf4f3c762e7160f38b4da56a784d9045190cfe;
  localparam logic [127:0] VB_C = 128'h1a6e6c2c662e7da6501ffb62bc9e93f3;
  logic clk = 1'b0, sys_rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*128-1:0] req_state, rsp_data;
  logic [NREQ*256-1:0] req_key;
  logic [127:0] core_state, core_out;
  logic [255:0] core_key;
  always #5 clk = ~clk;
  aes_256_arbiter #(.NREQ(NREQ), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .sys_clk(clk), .sys_rst(sys_rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_state(req_state), .req_key(req_key), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .core_state(core_state), .core_key(core_key), .core_out(core_out));
  // Stub core: known-answer vectors map to their real ciphertexts, anything else to a cheap mix
  function automatic logic [127:0] f(input logic [127:0] s, input logic [255:0] k);
    if (s == VA_S && k == VA_K) return VA_C;
    if (s == VB_S && k == VB_K) return VB_C;
    return {s[63:0], s[127:64]} ^ k[255:128] ^ k[127:0] ^ 128'h5a;
  endfunction
  logic [127:0] cpipe [LAT];
  always @(posedge clk) begin
    cpipe[0] <= f(core_state, core_key);
    for (int k = 1; k < LAT; k++) cpipe[k] <= cpipe[k-1];
  end
  assign core_out = cpipe[LAT-1];
  typedef struct {int due; logic [127:0] d;} ent_t;
  ent_t mq [NREQ][$];
  logic [127:0] got [NREQ][$];
  int mptr = NREQ - 1, cyc = 0, mg, cg, checks = 0, failures = 0;
  logic [127:0] ecs = '0;
  logic [255:0] eck = '0;
  bit armed = 1'b0;
  task automatic chk(input string nm, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, a, e);
    end
  endtask
  // Requester holds a credit per block that is in flight or still queued for it
  function automatic int exp_gnt();
    if (sys_rst) return -1;
    for (int k = 1; k <= NREQ; k++) begin
      int c = (mptr + k) % NREQ;
      if (req_valid[c] && mq[c].size() < DEPTH) return c;
    end
    return -1;
  endfunction
  always begin
    @(posedge clk);
    mg = exp_gnt();
    if (sys_rst) begin
      for (int i = 0; i < NREQ; i++) mq[i].delete();
      mptr = NREQ - 1; ecs = '0; eck = '0; armed = 1'b1;
    end else begin
      for (int i = 0; i < NREQ; i++)
        if (mq[i].size() > 0 && mq[i][0].due <= cyc && rsp_ready[i]) void'(mq[i].pop_front());
      if (mg >= 0) begin
        ecs = req_state[128*mg +: 128];
        eck = req_key[256*mg +: 256];
        mq[mg].push_back('{cyc + LAT + 2, f(ecs, eck)});
        mptr = mg;
      end else begin
        ecs = '0; eck = '0;
      end
    end
    cyc++;
  end
  always @(negedge clk) if (armed) begin
    cg = exp_gnt();
    for (int i = 0; i < NREQ; i++) begin
      bit ev;
      ev = mq[i].size() > 0 && mq[i][0].due <= cyc;
      chk("req_ready", 256'(req_ready[i]), 256'(cg == i));
      chk("rsp_valid", 256'(rsp_valid[i]), 256'(ev));
      if (ev) chk("rsp_data", 256'(rsp_data[128*i +: 128]), 256'(mq[i][0].d));
    end
    chk("core_state", 256'(core_state), 256'(ecs));
    chk("core_key", core_key, eck);
  end
  always @(negedge clk)
    for (int i = 0; i < NREQ; i++)
      if (!sys_rst && rsp_valid[i] && rsp_ready[i]) got[i].push_back(rsp_data[128*i +: 128]);
  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    sys_rst = 1'b1; tick(); tick(); sys_rst = 1'b0;
  endtask
  initial begin
    int lat, n1, n0, nv, w;
    bit v1;
    logic [127:0] d0;
    logic [127:0] exp6 [20];
    req_valid = '0; rsp_ready = '0; req_state = '0; req_key = '0;
    do_reset();
    #1;
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_core_state", 256'(core_state), 256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    // single block on ch0, end-to-end latency and known-answer data
    rsp_ready = 2'b11;
    req_state[127:0] = VA_S; req_key[255:0] = VA_K; req_state[255:128] = VB_S; req_key[511:256] = VB_K;
    req_valid = 2'b01;
    #1 chk("t1_hs", 256'(req_ready), 256'(2'b01));
    tick(); req_valid = '0;
    lat = -1; v1 = 1'b0; d0 = '0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (rsp_valid[1]) v1 = 1'b1;
      if (rsp_valid[0]) begin lat = n; d0 = rsp_data[127:0]; break; end
    end
    chk("t1_latency", 256'(lat), 256'(30));
    chk("t1_data", 256'(d0), 256'(VA_C));
    chk("t1_ch1_quiet", 256'(v1), 256'(0));
    // both channels streaming: alternating grants, known-answer data per channel
    do_reset();
    for (int i = 0; i < NREQ; i++) got[i].delete();
    req_valid = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_grant", 256'(req_ready), 256'(k % 2 ? 2'b10 : 2'b01));
      tick();
    end
    req_valid = '0;
    repeat (45) tick();
    chk("t2_ch0_count", 256'(got[0].size()), 256'(4));
    chk("t2_ch1_count", 256'(got[1].size()), 256'(4));
    chk("t2_ch0_data", 256'(got[0][0]), 256'(VA_C));
    chk("t2_ch1_data", 256'(got[1][3]), 256'(VB_C));
    // ch1 backpressured: credits stop it at exactly four grants
    do_reset();
    rsp_ready = 2'b01; req_valid = 2'b11; n1 = 0;
    for (int k = 0; k < 45; k++) begin
      #1 if (req_ready[1]) n1++;
      tick();
    end
    chk("t3_ch1_grants", 256'(n1), 256'(4));
    // pop with ch1 at full credit: grant only in the following cycle
    req_valid = 2'b10;
    #1 chk("t4_fifo_full", 256'(rsp_valid[1]), 256'(1));
    chk("t4_blocked", 256'(req_ready[1]), 256'(0));
    rsp_ready = 2'b11;
    #1 chk("t4_pop_cycle", 256'(req_ready[1]), 256'(0));
    tick();
    #1 chk("t4_next_cycle", 256'(req_ready[1]), 256'(1));
    tick(); req_valid = '0;
    repeat (40) tick();
    // reset mid-flight drops everything, arbitration resumes right after
    do_reset();
    rsp_ready = 2'b11; req_valid = 2'b01; n0 = 0;
    for (int k = 0; k < 3; k++) begin
      #1 if (req_ready[0]) n0++;
      tick();
    end
    req_valid = '0;
    chk("t5_issued", 256'(n0), 256'(3));
    repeat (9) tick();
    sys_rst = 1'b1; req_valid = 2'b01;
    #1 chk("t5_in_reset", 256'(req_ready[0]), 256'(0));
    tick(); sys_rst = 1'b0;
    #1 chk("t5_resume", 256'(req_ready[0]), 256'(1));
    req_valid = '0; nv = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (|rsp_valid) nv++;
    end
    chk("t5_dropped", 256'(nv), 256'(0));
    // single requester ch1 streams 20 distinct blocks
    do_reset();
    rsp_ready = 2'b10;
    for (int i = 0; i < NREQ; i++) got[i].delete();
    for (int k = 0; k < 20; k++) begin
      req_state[255:128] = 128'hdeadbeef_0badf00d_00000000_00000000 ^ 128'(k);
      req_key[511:256] = {8{32'(k * 7 + 1)}};
      exp6[k] = f(req_state[255:128], req_key[511:256]);
      req_valid = 2'b10;
      w = 0;
      #1;
      while (!req_ready[1] && w < 100) begin tick(); #1; w++; end
      chk("t6_grant", 256'(req_ready[1]), 256'(1));
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 300 && got[1].size() < 20; k++) tick();
    chk("t6_count", 256'(got[1].size()), 256'(20));
    for (int k = 0; k < 20; k++) chk("t6_order", 256'(got[1][k]), 256'(exp6[k]));
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
